// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the uart_tx parallel-in/serial-out shifter.
package piso_serializer_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_e;

   // Counter width for a WIDTH-bit word; at least one bit so the counter always exists.
   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      if (r < 1) begin
         r = 1;
      end else begin
         r = r;
      end
      return r;
   endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Word-load handshake between the tx framing logic and the serializer.
interface piso_serializer_if #(
   parameter int WIDTH = 8
);
   logic             din_valid;
   logic             din_ready;
   logic [WIDTH-1:0] din;

   modport master (output din_valid, output din, input din_ready);
   modport slave  (input din_valid, input din, output din_ready);
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out shifter: loads a word on valid/ready, emits one bit per tick_en,
// holds IDLE_LVL on dout while empty, and supports back-to-back words with no idle gap.
module piso_serializer
   import piso_serializer_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit LSB_FIRST = 1'b1,
   parameter bit IDLE_LVL  = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  tick_en,
   piso_serializer_if.slave      in_if,
   output logic                  dout,
   output logic                  busy,
   output logic                  done
);

   localparam int             CNT_W    = clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] sreg_q, sreg_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             dout_q, dout_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [WIDTH-1:0] shifted_s;
   logic             next_bit_s;
   logic             first_bit_s;
   logic             ready_s;

   // The register rotates rather than shifts; bit_cnt decides when the word is spent.
   generate
      if (LSB_FIRST) begin : g_lsb
         assign shifted_s   = {sreg_q[0], sreg_q[WIDTH-1:1]};
         assign next_bit_s  = shifted_s[0];
         assign first_bit_s = in_if.din[0];
      end else begin : g_msb
         assign shifted_s   = {sreg_q[WIDTH-2:0], sreg_q[WIDTH-1]};
         assign next_bit_s  = shifted_s[WIDTH-1];
         assign first_bit_s = in_if.din[WIDTH-1];
      end
   endgenerate

   // Next-state, datapath update and handshake decode.
   always_comb begin
      state_d = state_q;
      sreg_d  = sreg_q;
      cnt_d   = cnt_q;
      dout_d  = dout_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      ready_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            ready_s = 1'b1;
            if (in_if.din_valid) begin
               state_d = ST_SHIFT;
               sreg_d  = in_if.din;
               cnt_d   = {CNT_W{1'b0}};
               dout_d  = first_bit_s;
               busy_d  = 1'b1;
            end else begin
               dout_d  = IDLE_LVL;
               busy_d  = 1'b0;
            end
         end
         ST_SHIFT: begin
            if (tick_en && (cnt_q == LAST_CNT)) begin
               ready_s = 1'b1;
               done_d  = 1'b1;
               cnt_d   = {CNT_W{1'b0}};
               if (in_if.din_valid) begin
                  state_d = ST_SHIFT;
                  sreg_d  = in_if.din;
                  dout_d  = first_bit_s;
                  busy_d  = 1'b1;
               end else begin
                  state_d = ST_IDLE;
                  sreg_d  = {WIDTH{1'b0}};
                  dout_d  = IDLE_LVL;
                  busy_d  = 1'b0;
               end
            end else if (tick_en) begin
               cnt_d  = cnt_q + CNT_W'(1);
               sreg_d = shifted_s;
               dout_d = next_bit_s;
            end else begin
               cnt_d  = cnt_q;
               sreg_d = sreg_q;
               dout_d = dout_q;
            end
         end
         default: begin
            state_d = ST_IDLE;
            sreg_d  = {WIDTH{1'b0}};
            cnt_d   = {CNT_W{1'b0}};
            dout_d  = IDLE_LVL;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and output registers; reset discards any partial word.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         sreg_q  <= {WIDTH{1'b0}};
         cnt_q   <= {CNT_W{1'b0}};
         dout_q  <= IDLE_LVL;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sreg_q  <= sreg_d;
         cnt_q   <= cnt_d;
         dout_q  <= dout_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign in_if.din_ready = ready_s;
   assign dout            = dout_q;
   assign busy            = busy_q;
   assign done            = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: three configurations (8-bit LSB-first, 8-bit MSB-first,
// 2-bit LSB-first) share clock, reset and tick_en; sel picks which one is driven and observed.
module tb_piso_serializer;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       tick_en;
   logic       v_valid;
   logic [7:0] v_din;
   int         sel;
   int         n_assert = 0;
   int         n_fail   = 0;

   logic a_dout, a_busy, a_done;
   logic b_dout, b_busy, b_done;
   logic c_dout, c_busy, c_done;
   logic obs_dout, obs_busy, obs_done, obs_ready;

   always #5 clk = ~clk;

   piso_serializer_if #(.WIDTH(8)) a_if ();
   piso_serializer_if #(.WIDTH(8)) b_if ();
   piso_serializer_if #(.WIDTH(2)) c_if ();

   assign a_if.din_valid = v_valid && (sel == 0);
   assign a_if.din       = v_din;
   assign b_if.din_valid = v_valid && (sel == 1);
   assign b_if.din       = v_din;
   assign c_if.din_valid = v_valid && (sel == 2);
   assign c_if.din       = v_din[1:0];

   piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b1), .IDLE_LVL(1'b1)) dut_a (
      .clk(clk), .reset_n(reset_n), .tick_en(tick_en), .in_if(a_if),
      .dout(a_dout), .busy(a_busy), .done(a_done));

   piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b0), .IDLE_LVL(1'b1)) dut_b (
      .clk(clk), .reset_n(reset_n), .tick_en(tick_en), .in_if(b_if),
      .dout(b_dout), .busy(b_busy), .done(b_done));

   piso_serializer #(.WIDTH(2), .LSB_FIRST(1'b1), .IDLE_LVL(1'b1)) dut_c (
      .clk(clk), .reset_n(reset_n), .tick_en(tick_en), .in_if(c_if),
      .dout(c_dout), .busy(c_busy), .done(c_done));

   assign obs_dout  = (sel == 0) ? a_dout : (sel == 1) ? b_dout : c_dout;
   assign obs_busy  = (sel == 0) ? a_busy : (sel == 1) ? b_busy : c_busy;
   assign obs_done  = (sel == 0) ? a_done : (sel == 1) ? b_done : c_done;
   assign obs_ready = (sel == 0) ? a_if.din_ready : (sel == 1) ? b_if.din_ready : c_if.din_ready;

   task automatic chk(input string tag, input logic obs, input logic exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0b expected=%0b sel=%0d t=%0t", tag, obs, exp, sel, $time);
      end
   endtask

   // gap idle edges, then one edge with tick_en high
   task automatic do_tick(input int gap);
      repeat (gap) @(posedge clk);
      #1 tick_en = 1'b1;
      @(posedge clk);
      #1 tick_en = 1'b0;
   endtask

   task automatic send_word(input logic [7:0] w, input string seq, input int gap);
      @(posedge clk);
      #1 v_din = w; v_valid = 1'b1;
      @(posedge clk);
      #1 v_valid = 1'b0;
      @(negedge clk);
      chk("first_bit", obs_dout, seq[0] == "1");
      chk("busy_after_load", obs_busy, 1'b1);
      chk("ready_low_busy", obs_ready, 1'b0);
      for (int k = 1; k < seq.len(); k++) begin
         do_tick(gap);
         @(negedge clk);
         chk("bit", obs_dout, seq[k] == "1");
         chk("no_early_done", obs_done, 1'b0);
      end
      do_tick(gap);
      @(negedge clk);
      chk("done_pulse", obs_done, 1'b1);
      chk("busy_drop", obs_busy, 1'b0);
      chk("idle_level", obs_dout, 1'b1);
      chk("ready_idle", obs_ready, 1'b1);
      @(negedge clk);
      chk("done_one_cycle", obs_done, 1'b0);
   endtask

   initial begin
      reset_n = 1'b0;
      tick_en = 1'b0;
      v_valid = 1'b0;
      v_din   = 8'h00;
      sel     = 0;
      repeat (2) @(negedge clk);
      chk("rst_dout", obs_dout, 1'b1);
      chk("rst_busy", obs_busy, 1'b0);
      chk("rst_done", obs_done, 1'b0);
      chk("rst_ready", obs_ready, 1'b1);
      @(posedge clk);
      #1 reset_n = 1'b1;

      // LSB-first 8'hA5, tick every 16 clk
      sel = 0;
      send_word(8'hA5, "10100101", 15);

      // MSB-first
      sel = 1;
      send_word(8'hA5, "10100101", 3);
      send_word(8'h01, "00000001", 3);

      // back-to-back 8'h0F then 8'hF0 with din_valid held
      sel = 0;
      @(posedge clk);
      #1 v_din = 8'h0F; v_valid = 1'b1;
      @(posedge clk);
      #1 v_din = 8'hF0;
      @(negedge clk);
      chk("b2b_first", obs_dout, 1'b1);
      chk("b2b_ready_mid", obs_ready, 1'b0);
      for (int k = 1; k < 16; k++) begin
         do_tick(1);
         if (k == 8) v_valid = 1'b0;
         @(negedge clk);
         chk("b2b_bit", obs_dout, ((k % 8) >= 4) ? (k >= 8) : (k < 8));
         chk("b2b_busy", obs_busy, 1'b1);
         chk("b2b_done", obs_done, k == 8);
      end
      do_tick(1);
      @(negedge clk);
      chk("b2b_done2", obs_done, 1'b1);
      chk("b2b_busy_end", obs_busy, 1'b0);
      chk("b2b_idle", obs_dout, 1'b1);

      // din_valid with 8'h00 while 8'hFF is at bit 3
      @(posedge clk);
      #1 v_din = 8'hFF; v_valid = 1'b1;
      @(posedge clk);
      #1 v_valid = 1'b0;
      @(negedge clk);
      chk("ff_bit0", obs_dout, 1'b1);
      for (int k = 1; k < 4; k++) begin
         do_tick(2);
         @(negedge clk);
         chk("ff_bit", obs_dout, 1'b1);
      end
      @(posedge clk);
      #1 v_din = 8'h00; v_valid = 1'b1;
      @(negedge clk);
      chk("mid_ready_low", obs_ready, 1'b0);
      @(negedge clk);
      chk("mid_hold", obs_dout, 1'b1);
      chk("mid_busy", obs_busy, 1'b1);
      for (int k = 4; k < 8; k++) begin
         do_tick(2);
         @(negedge clk);
         chk("ff_tail", obs_dout, 1'b1);
         chk("ff_tail_ready", obs_ready, 1'b0);
      end
      do_tick(2);
      v_valid = 1'b0;
      @(negedge clk);
      chk("zero_load_done", obs_done, 1'b1);
      chk("zero_load_busy", obs_busy, 1'b1);
      chk("zero_load_bit0", obs_dout, 1'b0);
      for (int k = 1; k < 8; k++) begin
         do_tick(2);
         @(negedge clk);
         chk("zero_bit", obs_dout, 1'b0);
      end
      do_tick(2);
      @(negedge clk);
      chk("zero_done", obs_done, 1'b1);
      chk("zero_idle", obs_dout, 1'b1);

      // reset at bit 4 of 8'h00, then reload 8'h3C
      @(posedge clk);
      #1 v_din = 8'h00; v_valid = 1'b1;
      @(posedge clk);
      #1 v_valid = 1'b0;
      repeat (4) do_tick(2);
      @(negedge clk);
      chk("pre_rst_bit4", obs_dout, 1'b0);
      #1 reset_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("mid_rst_dout", obs_dout, 1'b1);
      chk("mid_rst_busy", obs_busy, 1'b0);
      chk("mid_rst_done", obs_done, 1'b0);
      @(posedge clk);
      #1 reset_n = 1'b1;
      send_word(8'h3C, "00111100", 3);

      // WIDTH=2, tick every clk
      sel = 2;
      send_word(8'h02, "01", 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
